round_robin_arbiter4: RTL
=========================

ROUND_ROBIN_ARBITER4 -- requirements
Module: round_robin_arbiter4

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, maximum consecutive cycles one grant is held before forced release (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req  input  4  request vector, bit i = requester i wants the shared resource.
REQ-005 SHALL have port done  input  1  current owner finished; releases grant at next edge.
REQ-006 SHALL have port gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 SHALL have port gnt_id  output  2  binary index of current owner; gnt is the 2-to-4 decode of gnt_id when busy.
REQ-008 SHALL have port busy  output  1  high while a grant is held.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is forcibly released by the hold limit.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-011 SHALL keep a 2-bit priority pointer ptr; search order is ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-012 IDLE: if req != 0 at an edge, SHALL move to GRANT, load gnt_id with first set req bit in search order, set busy=1, set gnt to one-hot of that index; latency req-to-gnt = 1 cycle.
REQ-013 IDLE with req == 0 SHALL remain IDLE with gnt=0, busy=0; gnt_id holds its last value.
REQ-014 GRANT: SHALL hold gnt, gnt_id unchanged while done=0, req[gnt_id]=1 and hold count below limit; requests from other bits have no effect.
REQ-015 GRANT: SHALL release at the edge where done=1 or req[gnt_id]=0; release = next state IDLE, gnt=0, busy=0, ptr=gnt_id+1 mod 4.
REQ-016 SHALL keep a hold counter cleared on entry to GRANT and incremented each GRANT cycle; width ceil(log2(HOLD_MAX))+1, no wrap.
REQ-017 GRANT cycle with count == HOLD_MAX-1 and no other release condition SHALL force release as REQ-015 and assert timeout=1 for exactly the following cycle.
REQ-018 If done=1 or req[gnt_id]=0 coincide with the hold limit, release SHALL be normal and timeout SHALL stay 0.
REQ-019 After any release SHALL spend at least one cycle in IDLE; next grant earliest 2 cycles after the release edge's preceding grant cycle (gap of one gnt=0 cycle).
REQ-020 gnt SHALL never have more than one bit set; gnt != 0 iff busy=1.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 Fairness: a requester holding req continuously SHALL be granted within 3 other grants.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, gnt=4'b0000, gnt_id=2'b00, busy=0, timeout=0, ptr=2'b00, hold counter=0, regardless of state, including mid-grant.
REQ-024 rst SHALL take priority over all other inputs; first grant after reset deasserts follows REQ-012 with ptr=0.

Verification
REQ-025 Reset, then req=4'b1010 held: gnt=4'b0010 one cycle later, gnt_id=1, busy=1.
REQ-026 Owner 1, pulse done: next cycle gnt=0; following cycle with req=4'b1010 still set gnt=4'b1000 (ptr=2 skips bit 1).
REQ-027 req=4'b1111 held, done pulsed each grant cycle: grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-028 HOLD_MAX=8, req=4'b0100 held, done=0: gnt=4'b0100 for exactly 8 cycles, then gnt=0 with timeout=1 for one cycle, then re-grant to 2.
REQ-029 Owner 3 mid-grant, assert rst one cycle: next cycle gnt=0, busy=0; with req=4'b1001 after reset release, gnt=4'b0001.
REQ-030 Owner 0, drop req[0] while req[2]=1: release next edge, then gnt=4'b0100; timeout stays 0 throughout.

Source files
------------

// File: rtl/round_robin_arbiter4.sv
// Four-way round-robin arbiter with per-grant hold limit and forced-release timeout pulse.
// A grant is held until done, until the owner drops its request, or until HOLD_MAX cycles elapse.
module round_robin_arbiter4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned CNT_W = $clog2(HOLD_MAX) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       gnt_n;
    logic [1:0]       gnt_id_n;
    logic             busy_n;
    logic             timeout_n;

    logic [1:0]       pick;
    logic             found;
    logic             normal_rel;
    logic             limit_hit;

    // First requester at or after ptr, wrapping modulo 4
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[2'(ptr + 2'(i))]) begin
                pick  = 2'(ptr + 2'(i));
                found = 1'b1;
            end
        end
    end

    assign normal_rel = done || !req[gnt_id];
    assign limit_hit  = (cnt == CNT_W'(HOLD_MAX - 1));

    // Next-state and registered-output values
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        busy_n    = busy;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n  = GRANT;
                    gnt_id_n = pick;
                    gnt_n    = 4'(1) << pick;
                    busy_n   = 1'b1;
                    cnt_n    = '0;
                end
            end
            GRANT: begin
                if (normal_rel || limit_hit) begin
                    state_n   = IDLE;
                    gnt_n     = 4'b0000;
                    busy_n    = 1'b0;
                    ptr_n     = 2'(gnt_id + 2'd1);
                    timeout_n = !normal_rel;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'b00;
            cnt     <= '0;
            gnt     <= 4'b0000;
            gnt_id  <= 2'b00;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            busy    <= busy_n;
            timeout <= timeout_n;
        end
    end

endmodule
